// File: rtl/stream_argmax.sv
// Pipelined max/argmax reduction over multi-beat rows with valid/ready backpressure.
// Optional lane masking is enabled by defining STREAM_ARGMAX_MASK_EN.
module stream_argmax #(
    parameter int BIT_WIDTH = 16,
    parameter int LANES     = 32,
    parameter int MAX_BEATS = 8,
    parameter int SIGNED    = 1,
    parameter int STAGES    = $clog2(LANES),
    parameter int IDX_W     = $clog2(LANES*MAX_BEATS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [BIT_WIDTH*LANES-1:0] i_data,
`ifdef STREAM_ARGMAX_MASK_EN
    input  logic [LANES-1:0]           i_mask,
    output logic                       o_all_masked,
`endif
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [BIT_WIDTH-1:0]       o_max,
    output logic [IDX_W-1:0]           o_idx,
    output logic                       o_err
);
    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int TAG_W  = BEAT_W + 2;
    localparam logic S_IDLE  = 1'b0;
    localparam logic S_ACCUM = 1'b1;

    function automatic logic gt(input logic [BIT_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    logic                 adv, accept, trunc, last_eff;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic [STAGES-1:0]    vld_q;
    logic [TAG_W-1:0]     tag_q [STAGES];
    logic [BIT_WIDTH-1:0] leaf_v [LANES];
    logic [BIT_WIDTH-1:0] nd_v [1:LANES-1];
    logic [LANE_W-1:0]    nd_i [1:LANES-1];
    logic [BIT_WIDTH-1:0] node_v_q [1:LANES-1];
    logic [LANE_W-1:0]    node_i_q [1:LANES-1];

    assign adv      = !o_valid || i_ready;
    assign o_ready  = adv;
    assign accept   = i_valid && adv;
    assign trunc    = (cnt_q == BEAT_W'(MAX_BEATS-1)) && !i_last;
    assign last_eff = i_last || trunc;
    assign cnt_d    = last_eff ? '0 : cnt_q + 1'b1;

`ifdef STREAM_ARGMAX_MASK_EN
    localparam logic [BIT_WIDTH-1:0] MIN_V = (SIGNED != 0) ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : '0;
    logic [STAGES-1:0] any_q;
`endif

    // Leaves feed the first tree stage combinationally; lane l is leaf l.
    for (genvar l = 0; l < LANES; l++) begin : g_leaf
`ifdef STREAM_ARGMAX_MASK_EN
        assign leaf_v[l] = i_mask[l] ? i_data[l*BIT_WIDTH +: BIT_WIDTH] : MIN_V;
`else
        assign leaf_v[l] = i_data[l*BIT_WIDTH +: BIT_WIDTH];
`endif
    end

    // Heap-ordered tree: node n compares children 2n (left, wins ties) and 2n+1.
    for (genvar n = 1; n < LANES; n++) begin : g_node
        if (2*n >= LANES) begin : g_l
            localparam int A = 2*n - LANES;
            logic rgt;
            assign rgt     = gt(leaf_v[A+1], leaf_v[A]);
            assign nd_v[n] = rgt ? leaf_v[A+1] : leaf_v[A];
            assign nd_i[n] = rgt ? LANE_W'(A+1) : LANE_W'(A);
        end else begin : g_i
            logic rgt;
            assign rgt     = gt(node_v_q[2*n+1], node_v_q[2*n]);
            assign nd_v[n] = rgt ? node_v_q[2*n+1] : node_v_q[2*n];
            assign nd_i[n] = rgt ? node_i_q[2*n+1] : node_i_q[2*n];
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv) begin
            node_v_q <= nd_v;
            node_i_q <= nd_i;
            tag_q[0] <= {last_eff, trunc, cnt_q};
            for (int k = 1; k < STAGES; k++) tag_q[k] <= tag_q[k-1];
`ifdef STREAM_ARGMAX_MASK_EN
            any_q[0] <= |i_mask;
            for (int k = 1; k < STAGES; k++) any_q[k] <= any_q[k-1];
`endif
        end
    end

    // Accumulator / result stage.
    logic                 state_q, state_d;
    logic [BIT_WIDTH-1:0] acc_max_q, acc_max_d, m_max, o_max_q, o_max_d;
    logic [IDX_W-1:0]     acc_idx_q, acc_idx_d, m_idx, beat_idx, o_idx_q, o_idx_d;
    logic                 o_valid_q, o_valid_d, o_err_q, o_err_d, take;
    logic                 rt_last, rt_err;
    logic [BEAT_W-1:0]    rt_beat;

    assign {rt_last, rt_err, rt_beat} = tag_q[STAGES-1];

`ifdef STREAM_ARGMAX_MASK_EN
    logic acc_any_q, acc_any_d, m_any, o_am_q, o_am_d;
`endif

    always_comb begin
        state_d   = state_q;
        acc_max_d = acc_max_q;
        acc_idx_d = acc_idx_q;
        o_valid_d = o_valid_q;
        o_max_d   = o_max_q;
        o_idx_d   = o_idx_q;
        o_err_d   = o_err_q;
        beat_idx  = (IDX_W'(rt_beat) << LANE_W) | IDX_W'(node_i_q[1]);
        take      = (state_q == S_IDLE) || gt(node_v_q[1], acc_max_q);
        m_max     = take ? node_v_q[1] : acc_max_q;
        m_idx     = take ? beat_idx : acc_idx_q;
`ifdef STREAM_ARGMAX_MASK_EN
        acc_any_d = acc_any_q;
        o_am_d    = o_am_q;
        m_any     = ((state_q == S_IDLE) ? 1'b0 : acc_any_q) | any_q[STAGES-1];
`endif
        if (adv) begin
            o_valid_d = 1'b0;
            if (vld_q[STAGES-1]) begin
                if (rt_last) begin
                    o_valid_d = 1'b1;
                    o_max_d   = m_max;
                    o_idx_d   = m_idx;
                    o_err_d   = rt_err;
                    state_d   = S_IDLE;
`ifdef STREAM_ARGMAX_MASK_EN
                    o_am_d    = !m_any;
`endif
                end else begin
                    acc_max_d = m_max;
                    acc_idx_d = m_idx;
                    state_d   = S_ACCUM;
`ifdef STREAM_ARGMAX_MASK_EN
                    acc_any_d = m_any;
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        acc_max_q <= acc_max_d;
        acc_idx_q <= acc_idx_d;
`ifdef STREAM_ARGMAX_MASK_EN
        acc_any_q <= acc_any_d;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q     <= '0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            o_valid_q <= 1'b0;
            o_max_q   <= '0;
            o_idx_q   <= '0;
            o_err_q   <= 1'b0;
`ifdef STREAM_ARGMAX_MASK_EN
            o_am_q    <= 1'b0;
`endif
        end else begin
            if (adv) begin
                vld_q[0] <= accept;
                for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
            end
            if (accept) cnt_q <= cnt_d;
            state_q   <= state_d;
            o_valid_q <= o_valid_d;
            o_max_q   <= o_max_d;
            o_idx_q   <= o_idx_d;
            o_err_q   <= o_err_d;
`ifdef STREAM_ARGMAX_MASK_EN
            o_am_q    <= o_am_d;
`endif
        end
    end

    assign o_valid = o_valid_q;
    assign o_max   = o_max_q;
    assign o_idx   = o_idx_q;
    assign o_err   = o_err_q;
`ifdef STREAM_ARGMAX_MASK_EN
    assign o_all_masked = o_am_q;
`endif

endmodule

// File: tb/tb_stream_argmax.sv
// Directed bench for stream_argmax: signed and unsigned instances driven in parallel.
module tb_stream_argmax;
    localparam int BW = 16;
    localparam int LN = 32;
    localparam int MB = 8;
    localparam int IW = 8;
    localparam int DW = BW*LN;

    logic          i_clk = 1'b0;
    logic          i_rst, i_valid, i_last, i_ready;
    logic [DW-1:0] i_data;
    logic          o_ready_s, o_valid_s, o_err_s, o_ready_u, o_valid_u, o_err_u;
    logic [BW-1:0] o_max_s, o_max_u;
    logic [IW-1:0] o_idx_s, o_idx_u;
`ifdef STREAM_ARGMAX_MASK_EN
    logic [LN-1:0] i_mask;
    logic          o_am_s, o_am_u;
`endif

    always #5 i_clk = ~i_clk;

    stream_argmax #(.BIT_WIDTH(BW), .LANES(LN), .MAX_BEATS(MB), .SIGNED(1)) dut_s (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_s), .i_data(i_data),
`ifdef STREAM_ARGMAX_MASK_EN
        .i_mask(i_mask), .o_all_masked(o_am_s),
`endif
        .i_last(i_last), .o_valid(o_valid_s), .i_ready(i_ready),
        .o_max(o_max_s), .o_idx(o_idx_s), .o_err(o_err_s));

    stream_argmax #(.BIT_WIDTH(BW), .LANES(LN), .MAX_BEATS(MB), .SIGNED(0)) dut_u (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_u), .i_data(i_data),
`ifdef STREAM_ARGMAX_MASK_EN
        .i_mask(i_mask), .o_all_masked(o_am_u),
`endif
        .i_last(i_last), .o_valid(o_valid_u), .i_ready(i_ready),
        .o_max(o_max_u), .o_idx(o_idx_u), .o_err(o_err_u));

    typedef struct packed {
        logic [BW-1:0] mx;
        logic [IW-1:0] idx;
        logic          err;
        logic          am;
    } res_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [BW-1:0] smx;
        logic [IW-1:0] sidx;
        logic [BW-1:0] umx;
        logic [IW-1:0] uidx;
    } vec_t;

    res_t qs[$];
    res_t qu[$];
    vec_t tv[6];
    int   total = 0;
    int   bad = 0;

    // Results are captured on the negedge preceding the accepting posedge.
    always @(negedge i_clk) begin
        if (!i_rst && i_ready) begin
`ifdef STREAM_ARGMAX_MASK_EN
            if (o_valid_s) qs.push_back('{o_max_s, o_idx_s, o_err_s, o_am_s});
            if (o_valid_u) qu.push_back('{o_max_u, o_idx_u, o_err_u, o_am_u});
`else
            if (o_valid_s) qs.push_back('{o_max_s, o_idx_s, o_err_s, 1'b0});
            if (o_valid_u) qu.push_back('{o_max_u, o_idx_u, o_err_u, 1'b0});
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [BW-1:0] v);
        logic [DW-1:0] d;
        for (int k = 0; k < LN; k++) d[k*BW +: BW] = v;
        return d;
    endfunction

    task automatic put(input logic [DW-1:0] d, input logic last);
        int g;
        i_data  = d;
        i_last  = last;
        i_valid = 1'b1;
        g = 0;
        @(negedge i_clk);
        while (!o_ready_s && g < 100) begin
            @(negedge i_clk);
            g++;
        end
        if (!o_ready_s) chk("ready_timeout", 32'(o_ready_s), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int g;
        g = 0;
        while ((qs.size() < n || qu.size() < n) && g < 60) begin
            @(posedge i_clk);
            #1;
            g++;
        end
        chk("result_count", 32'(qs.size()), 32'(n));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        logic [DW-1:0] d, b0;
        int lat;
        int g;

        for (int k = 0; k < LN; k++) tv[0].d[k*BW +: BW] = BW'(k - 16);
        tv[0].smx = 16'd15;   tv[0].sidx = 8'd31; tv[0].umx = 16'hFFFF; tv[0].uidx = 8'd15;
        tv[1].d = fill(16'd1); tv[1].d[0 +: BW] = 16'hFFFF;
        tv[1].smx = 16'd1;    tv[1].sidx = 8'd1;  tv[1].umx = 16'hFFFF; tv[1].uidx = 8'd0;
        tv[2].d = fill(16'd7);
        tv[2].smx = 16'd7;    tv[2].sidx = 8'd0;  tv[2].umx = 16'd7;    tv[2].uidx = 8'd0;
        tv[3].d = fill(16'hFFFB); tv[3].d[31*BW +: BW] = 16'h8000;
        tv[3].smx = 16'hFFFB; tv[3].sidx = 8'd0;  tv[3].umx = 16'hFFFB; tv[3].uidx = 8'd0;
        tv[4].d = fill(16'd0); tv[4].d[10*BW +: BW] = 16'h7FFF; tv[4].d[20*BW +: BW] = 16'h7FFF;
        tv[4].smx = 16'h7FFF; tv[4].sidx = 8'd10; tv[4].umx = 16'h7FFF; tv[4].uidx = 8'd10;
        tv[5].d = fill(16'h8000); tv[5].d[3*BW +: BW] = 16'h8001;
        tv[5].smx = 16'h8001; tv[5].sidx = 8'd3;  tv[5].umx = 16'h8001; tv[5].uidx = 8'd3;

        i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1; i_data = '0;
`ifdef STREAM_ARGMAX_MASK_EN
        i_mask = '1;
`endif
        cyc(3);
        chk("rst_valid", 32'(o_valid_s), 32'd0);
        chk("rst_max", 32'(o_max_s), 32'd0);
        chk("rst_idx", 32'(o_idx_s), 32'd0);
        chk("rst_err", 32'(o_err_s), 32'd0);
        chk("rst_ready", 32'(o_ready_s), 32'd1);
        i_rst = 1'b0;
        cyc(1);

        // Single-beat latency.
        put(tv[0].d, 1'b1);
        lat = 1;
        while (!o_valid_s && lat < 20) begin
            cyc(1);
            lat++;
        end
        chk("latency", 32'(lat), 32'd6);
        chk("lat_max", 32'(o_max_s), 32'd15);
        chk("lat_idx", 32'(o_idx_s), 32'd31);
        chk("lat_err", 32'(o_err_s), 32'd0);
        cyc(1);
        chk("valid_pulse", 32'(o_valid_s), 32'd0);
        cyc(2);
        qs.delete(); qu.delete();

        for (int i = 0; i < 6; i++) begin
            put(tv[i].d, 1'b1);
            wait_res(1);
            if (qs.size() > 0 && qu.size() > 0) begin
                chk($sformatf("tv%0d_smax", i), 32'(qs[0].mx), 32'(tv[i].smx));
                chk($sformatf("tv%0d_sidx", i), 32'(qs[0].idx), 32'(tv[i].sidx));
                chk($sformatf("tv%0d_serr", i), 32'(qs[0].err), 32'd0);
                chk($sformatf("tv%0d_umax", i), 32'(qu[0].mx), 32'(tv[i].umx));
                chk($sformatf("tv%0d_uidx", i), 32'(qu[0].idx), 32'(tv[i].uidx));
            end
            cyc(2);
            qs.delete(); qu.delete();
        end

        // Three-beat row with a tie across beats.
        b0 = fill(16'hFFFB);
        put(b0, 1'b0);
        d = b0; d[7*BW +: BW] = 16'd100; put(d, 1'b0);
        d = b0; d[3*BW +: BW] = 16'd100; put(d, 1'b1);
        wait_res(1);
        cyc(10);
        chk("multi_count", 32'(qs.size()), 32'd1);
        if (qs.size() > 0 && qu.size() > 0) begin
            chk("multi_smax", 32'(qs[0].mx), 32'd100);
            chk("multi_sidx", 32'(qs[0].idx), 32'd39);
            chk("multi_umax", 32'(qu[0].mx), 32'hFFFB);
            chk("multi_uidx", 32'(qu[0].idx), 32'd0);
        end
        qs.delete(); qu.delete();

        // Nine beats, i_last only on the ninth: truncation at MAX_BEATS.
        for (int b = 0; b < 9; b++) begin
            d = fill(16'd0);
            if (b < 8) d[0 +: BW] = BW'(b*10);
            else       d[5*BW +: BW] = 16'd42;
            put(d, b == 8);
        end
        wait_res(2);
        if (qs.size() > 1) begin
            chk("trunc_max", 32'(qs[0].mx), 32'd70);
            chk("trunc_idx", 32'(qs[0].idx), 32'd224);
            chk("trunc_err", 32'(qs[0].err), 32'd1);
            chk("next_max", 32'(qs[1].mx), 32'd42);
            chk("next_idx", 32'(qs[1].idx), 32'd5);
            chk("next_err", 32'(qs[1].err), 32'd0);
        end
        cyc(2);
        qs.delete(); qu.delete();

        // Backpressure: four single-beat rows, downstream stalled.
        i_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            d = fill(16'd0);
            d[3*r*BW +: BW] = BW'(50 + r);
            put(d, 1'b1);
        end
        g = 0;
        while (!o_valid_s && g < 20) begin
            cyc(1);
            g++;
        end
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 32'(o_valid_s), 32'd1);
            chk("bp_ready", 32'(o_ready_s), 32'd0);
            chk("bp_max", 32'(o_max_s), 32'd50);
            chk("bp_idx", 32'(o_idx_s), 32'd0);
            cyc(1);
        end
        i_ready = 1'b1;
        wait_res(4);
        cyc(10);
        chk("bp_count", 32'(qs.size()), 32'd4);
        for (int r = 0; r < 4; r++) begin
            if (qs.size() > r) begin
                chk($sformatf("bp%0d_max", r), 32'(qs[r].mx), 32'(50 + r));
                chk($sformatf("bp%0d_idx", r), 32'(qs[r].idx), 32'(3*r));
            end
        end
        qs.delete(); qu.delete();

        // Reset mid-row, then a clean single-beat row.
        d = fill(16'd0); d[0 +: BW] = 16'd99;
        put(d, 1'b0);
        put(d, 1'b0);
        #3;
        i_rst = 1'b1;
        #1;
        chk("arst_max", 32'(o_max_s), 32'd0);
        chk("arst_valid", 32'(o_valid_s), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        cyc(1);
        d = fill(16'd0); d[9*BW +: BW] = 16'd77;
        put(d, 1'b1);
        wait_res(1);
        cyc(12);
        chk("rst_row_count", 32'(qs.size()), 32'd1);
        if (qs.size() > 0) begin
            chk("rst_row_max", 32'(qs[0].mx), 32'd77);
            chk("rst_row_idx", 32'(qs[0].idx), 32'd9);
            chk("rst_row_err", 32'(qs[0].err), 32'd0);
        end
        qs.delete(); qu.delete();

`ifdef STREAM_ARGMAX_MASK_EN
        i_mask = '0;
        put(fill(16'h1234), 1'b1);
        wait_res(1);
        if (qs.size() > 0 && qu.size() > 0) begin
            chk("mask_all_am", 32'(qs[0].am), 32'd1);
            chk("mask_all_max", 32'(qs[0].mx), 32'h8000);
            chk("mask_all_idx", 32'(qs[0].idx), 32'd0);
            chk("mask_all_umax", 32'(qu[0].mx), 32'd0);
        end
        cyc(2);
        qs.delete(); qu.delete();
        i_mask = '1;
        i_mask[5] = 1'b0;
        d = fill(16'd1); d[5*BW +: BW] = 16'h7FFF;
        put(d, 1'b1);
        wait_res(1);
        if (qs.size() > 0) begin
            chk("mask_part_am", 32'(qs[0].am), 32'd0);
            chk("mask_part_max", 32'(qs[0].mx), 32'd1);
            chk("mask_part_idx", 32'(qs[0].idx), 32'd0);
        end
        i_mask = '1;
        cyc(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_argmax.md
Name: stream_argmax

Overview:
- Pipelined max + argmax reduction over rows longer than one input beat.
- A row arrives as 1..MAX_BEATS beats of LANES elements; the last beat is tagged with i_last.
- Emits one result per row: maximum value, its global element index, and an error flag.
- Feeds the softmax datapath. Generalises the single-beat max tree with multi-beat accumulation, argmax, signed/unsigned mode and valid/ready backpressure.

Parameters:
- BIT_WIDTH, 16, element width in bits.
- LANES, 32, elements per beat; power of two, >= 2.
- MAX_BEATS, 8, maximum beats per row; >= 1.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.
- STAGES, $clog2(LANES), number of comparator-tree stages (derived).
- IDX_W, $clog2(LANES*MAX_BEATS), width of the global index.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_data  input  BIT_WIDTH x LANES  beat elements; lane i carries global index beat*LANES+i.
- i_last  input  1  marks the final beat of the row.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_max  output  BIT_WIDTH  row maximum.
- o_idx  output  IDX_W  global index of the maximum.
- o_err  output  1  row was truncated at MAX_BEATS.

Behaviour:
- Reset: o_valid=0, o_max=0, o_idx=0, o_err=0, all pipeline valid bits 0, beat counter 0, accumulator state IDLE.
- Reset is asynchronous and may occur mid-row or mid-pipeline; all partial rows are discarded and no result is emitted.
- Handshake:
  - adv = !o_valid || i_ready; o_ready = adv.
  - A beat is accepted when i_valid && o_ready.
  - When adv=0, the whole pipeline holds and o_max/o_idx/o_err stay stable.
  - o_valid stays high until i_ready.
- Tree:
  - STAGES registered stages, each halving the candidate count.
  - Each candidate carries {value, lane index}.
  - Compare is signed when SIGNED=1, otherwise unsigned.
  - Ties select the lower index (left operand wins on equality).
  - Beat tag {last, beat#} travels alongside the candidates.
- Accumulator stage (one register stage after the tree):
  - IDLE: a tree-output beat loads acc_max and acc_idx = beat#*LANES + lane, then goes to ACCUM. If the beat has last, it emits directly.
  - ACCUM: the beat replaces the accumulator only if strictly greater, so ties keep the earlier index.
  - On a last beat, the result registers load the merged value, o_valid=1, and the state returns to IDLE.
- Beat counter:
  - Increments per accepted beat and clears on an accepted last beat.
  - If beat MAX_BEATS-1 is accepted without i_last, it is treated as last and the row's o_err=1; the next beat starts a new row.
- Latency: the result appears STAGES+1 cycles after the last beat is accepted, absent stalls.
- Throughput: one beat per cycle. Back-to-back rows are allowed, including single-beat rows every cycle.
- Index width: IDX_W = $clog2(LANES*MAX_BEATS); for MAX_BEATS=1 it is $clog2(LANES).

Optional Feature:
- Macro: STREAM_ARGMAX_MASK_EN.
- Defined:
  - Adds port i_mask (input, LANES bits); 1 = lane valid.
  - Masked lanes enter the tree as the minimum representable value (signed: 1 followed by zeros; unsigned: 0) and keep their index.
  - If a row is fully masked: o_max = that minimum, o_idx = 0.
  - Adds output o_all_masked, reset 0, valid with o_valid.
- Undefined: no i_mask or o_all_masked ports; all lanes participate.

Test Plan:
- LANES=32, SIGNED=1, single beat with lane i = i-16, last=1, i_ready=1 -> after 6 cycles o_valid=1, o_max=15, o_idx=31, o_err=0.
- 3-beat row: all elements -5 except beat1 lane7 = 100 and beat2 lane3 = 100 -> o_max=100, o_idx=39 (tie keeps the earlier index), one result.
- Signed vs unsigned: one beat with lane0 = 16'hFFFF, others 1 -> SIGNED=1 gives o_max=1, o_idx=1; SIGNED=0 gives o_max=16'hFFFF, o_idx=0.
- Backpressure: 4 single-beat rows back-to-back, i_ready=0 for 10 cycles -> o_ready drops, o_max/o_idx stay stable; after release all 4 results appear in order with no loss.
- MAX_BEATS=8: 9 beats, i_last only on beat 8 -> first result has o_err=1 covering beats 0-7; second result is the 1-beat row with o_err=0.
- Reset asserted mid-row after 2 beats, then a clean 1-beat row -> exactly one result, for the clean row. With STREAM_ARGMAX_MASK_EN defined, an all-zero i_mask row -> o_all_masked=1, o_max=16'h8000, o_idx=0.
